adder_share_arbiter: RTL and testbench

//   Shares one N-bit ripple-carry adder among NREQ requesters. Arbitrates

---
 rtl/adder_arb_pkg.sv | 19 +
 rtl/rca_adder.sv | 23 ++
 rtl/adder_share_arbiter.sv | 140 ++++++++++++++
 tb/tb_adder_share_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder-sharing arbiter: FSM encoding, default sizes
// and the requester-id width helper.
package adder_arb_pkg;

    localparam int N_DEF    = 8;
    localparam int NREQ_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Never narrower than one bit, so a single-requester build still has an id port.
    function automatic int id_width(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/rca_adder.sv
// N-bit ripple-carry adder built as an explicit chain of full-adder cells.
module rca_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[N];

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one ripple-carry adder among NREQ valid/ready requesters, one op in flight.
// ADD_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise lowest index wins.
//
// state | meaning
// IDLE  | offer req_ready to the arbitration winner, latch its operands on handshake
// CALC  | adder sees latched operands; result registered at the edge
// DONE  | result held on res_* until res_ready
module adder_share_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int NREQ = NREQ_DEF,
    parameter int ID_W = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N-1:0]      res_sum,
    output logic              res_carry,
    output logic [ID_W-1:0]   res_id
);

    state_t          state, state_nxt;
    logic [N-1:0]    a_q, b_q;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] grant;
    logic            any_valid;
    logic            accept;
    logic [N-1:0]    add_sum;
    logic            add_cout;

    assign any_valid = |req_valid;

`ifdef ADD_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] ptr;

    // Walk downward so the candidate closest to the pointer is the last to win.
    function automatic logic [ID_W-1:0] arb_pick(input logic [NREQ-1:0] v,
                                                 input logic [ID_W-1:0] p);
        logic [ID_W-1:0] g;
        int              idx;
        g = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NREQ;
            if (v[idx]) g = ID_W'(idx);
        end
        return g;
    endfunction

    assign grant = arb_pick(req_valid, ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (grant == ID_W'(NREQ - 1)) ? '0 : grant + 1'b1;
        end
    end
`else
    function automatic logic [ID_W-1:0] arb_pick(input logic [NREQ-1:0] v);
        logic [ID_W-1:0] g;
        g = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (v[k]) g = ID_W'(k);
        end
        return g;
    endfunction

    assign grant = arb_pick(req_valid);
`endif

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                // rst gating keeps req_ready low for the whole reset pulse
                if (any_valid && !rst) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    state_nxt        = ST_CALC;
                end
            end
            ST_CALC: state_nxt = ST_DONE;
            ST_DONE: if (res_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            id_q <= '0;
        end else if (accept) begin
            a_q  <= req_a[grant*N +: N];
            b_q  <= req_b[grant*N +: N];
            id_q <= grant;
        end
    end

    rca_adder #(.N(N)) u_adder (
        .a    (a_q),
        .b    (b_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_carry <= 1'b0;
            res_id    <= '0;
        end else if (state == ST_CALC) begin
            res_valid <= 1'b1;
            res_sum   <= add_sum;
            res_carry <= add_cout;
            res_id    <= id_q;
        end else if (state == ST_DONE && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter; follows ADD_ARB_ROUND_ROBIN_EN like the RTL.
module tb_adder_share_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic              res_valid;
    logic              res_ready;
    logic [N-1:0]      res_sum;
    logic              res_carry;
    logic [ID_W-1:0]   res_id;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int model_ptr = 0;

    adder_share_arbiter #(.N(N), .NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .res_id    (res_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]   valid;
        logic [NREQ*N-1:0] a;
        logic [NREQ*N-1:0] b;
        int                exp_id;
        int                exp_sum;
        int                exp_carry;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Winner chosen from the arbitration rule: first valid index scanning from the
    // pointer (round-robin) or from index 0 (fixed priority).
    function automatic int model_grant(input logic [NREQ-1:0] v);
        int start;
`ifdef ADD_ARB_ROUND_ROBIN_EN
        start = model_ptr;
`else
        start = 0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (v[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int slice(input logic [NREQ*N-1:0] bus, input int i);
        return int'(bus[i*N +: N]);
    endfunction

    // Entered shortly after a negedge-ish point with the DUT in IDLE; leaves it in IDLE.
    task automatic run_op(input logic [NREQ-1:0] v, input int bp_cycles, output int got_id);
        int g, total;
        logic [N-1:0] s_hold;
        req_valid = v;
        res_ready = (bp_cycles == 0);
        #1;
        g = model_grant(v);
        got_id = -1;
        if (g < 0) begin
            chk("idle_ready", req_ready, 0);
            @(posedge clk); #1;
            chk("idle_no_result", res_valid, 0);
            chk("idle_ready_hold", req_ready, 0);
            return;
        end
        chk("grant_ready", req_ready, 1 << g);
        total = slice(req_a, g) + slice(req_b, g);
        @(posedge clk); #1;
`ifdef ADD_ARB_ROUND_ROBIN_EN
        model_ptr = (g + 1) % NREQ;
`endif
        chk("calc_ready", req_ready, 0);
        chk("calc_no_valid", res_valid, 0);
        @(posedge clk); #1;
        chk("res_valid", res_valid, 1);
        chk("res_sum", res_sum, total % 256);
        chk("res_carry", res_carry, (total > 255) ? 1 : 0);
        chk("res_id", res_id, g);
        got_id = int'(res_id);
        s_hold = res_sum;
        for (int c = 0; c < bp_cycles; c++) begin
            @(posedge clk); #1;
            chk("bp_valid", res_valid, 1);
            chk("bp_sum", res_sum, s_hold);
            chk("bp_id", res_id, g);
            chk("bp_ready", req_ready, 0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("res_drop", res_valid, 0);
        chk("res_keep_sum", res_sum, total % 256);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        #1;
    endtask

    vec_t vecs[5];
    int   id;
    int   seq_exp[5];

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_sum", res_sum, 0);
        chk("rst_carry", res_carry, 0);
        chk("rst_id", res_id, 0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        model_ptr = 0;

        vecs[0] = '{4'b0001, 32'h0000_00BA, 32'h0000_00EB, 0, 8'hA5, 1};
        vecs[1] = '{4'b0100, 32'h00FF_0000, 32'h0001_0000, 2, 8'h00, 1};
        vecs[2] = '{4'b0010, 32'h0000_0000, 32'h0000_0000, 1, 8'h00, 0};
        vecs[3] = '{4'b1000, 32'h8000_0000, 32'h8100_0000, 3, 8'h01, 1};
        vecs[4] = '{4'b0001, 32'h0000_0010, 32'h0000_0020, 0, 8'h30, 0};
        foreach (vecs[i]) begin
            req_a = vecs[i].a;
            req_b = vecs[i].b;
            run_op(vecs[i].valid, 0, id);
            chk("tbl_id", id, vecs[i].exp_id);
            chk("tbl_sum", res_sum, vecs[i].exp_sum);
            chk("tbl_carry", res_carry, vecs[i].exp_carry);
        end

        for (int i = 0; i < 40; i++) begin
            req_a = {$urandom};
            req_b = {$urandom};
            run_op(NREQ'($urandom_range(0, 15)), (i % 7 == 3) ? 2 : 0, id);
        end

        // All requesters held valid from a fresh pointer
        do_reset();
`ifdef ADD_ARB_ROUND_ROBIN_EN
        seq_exp = '{0, 1, 2, 3, 0};
`else
        seq_exp = '{0, 0, 0, 0, 0};
`endif
        req_a = 32'h4433_2211;
        req_b = 32'h0102_0304;
        for (int i = 0; i < 5; i++) begin
            run_op(4'b1111, 0, id);
            chk("seq_id", id, seq_exp[i]);
        end
`ifndef ADD_ARB_ROUND_ROBIN_EN
        run_op(4'b1110, 0, id);
        chk("drop0_id", id, 1);
`endif

        // Backpressure, then immediate next accept
        req_a = 32'h7766_5544;
        req_b = 32'h1111_1111;
        run_op(4'b1111, 5, id);
        req_valid = 4'b0100;
        #1;
        chk("post_bp_ready", req_ready, 4'b0100);
        run_op(4'b0100, 0, id);

        // Asynchronous reset while CALC
        req_a = 32'h00F0_0000;
        req_b = 32'h0020_0000;
        req_valid = 4'b0100;
        res_ready = 1'b1;
        #1;
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        chk("pre_rst_valid", res_valid, 1);
        chk("pre_rst_sum", res_sum, 8'h10);
        @(posedge clk); #1;
        req_a = 32'h0000_0099;
        req_b = 32'h0000_0011;
        req_valid = 4'b0001;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", res_valid, 0);
        chk("arst_sum", res_sum, 0);
        chk("arst_carry", res_carry, 0);
        chk("arst_id", res_id, 0);
        chk("arst_ready", req_ready, 0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_stale", res_valid, 0);
        end
        req_a = 32'h0000_0010;
        req_b = 32'h0000_0020;
        run_op(4'b0001, 0, id);
        chk("reissue_sum", res_sum, 8'h30);
        chk("reissue_carry", res_carry, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
